// File: rtl/l1d_dual_entry_alloc_tracker.sv
//------------------------------------------------------------------------------
// Module      : l1d_dual_entry_alloc_tracker
// Description : Busy/free tracker for an N-entry pool (MSHR / line-fill
//               buffer). Grants up to two allocations and accepts up to two
//               releases per cycle. Port 0 takes the lowest free entry and
//               port 1 takes the highest free entry. Keeps a busy bitmap and an
//               occupancy counter.
// Options     : L1D_ALLOC_TRACKER_CHK_EN enables the sticky protocol-error
//               flag and its simulation assertion.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

// Picks the lowest and the highest set bit of a valid mask.
module select_two_from_n_valid #(
  parameter int N    = 8,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    sel_i,
  input  logic            first_id_needed_vld_i,
  input  logic            second_id_needed_vld_i,
  output logic            first_id_vld_o,
  output logic [ID_W-1:0] first_id_o,
  output logic            second_id_vld_o,
  output logic [ID_W-1:0] second_id_o
);

  // Lowest set index: scan downwards so the last hit found is the smallest.
  always_comb begin
    first_id_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (sel_i[i]) first_id_o = ID_W'(i);
    end
  end

  // Highest set index: scan upwards so the last hit found is the largest.
  always_comb begin
    second_id_o = '0;
    for (int i = 0; i < N; i++) begin
      if (sel_i[i]) second_id_o = ID_W'(i);
    end
  end

  assign first_id_vld_o = |sel_i;

  // The second grant is only offered when it is requested. When the first
  // grant is also requested, the two picks must be different entries. The
  // lowest and highest set bits differ only when at least two bits are set.
  assign second_id_vld_o = second_id_needed_vld_i & (|sel_i) &
                           (~first_id_needed_vld_i | (first_id_o != second_id_o));

endmodule

module l1d_dual_entry_alloc_tracker #(
  parameter int ENTRY_NUM = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alloc0_vld_i,
  output logic                          alloc0_rdy_o,
  output logic [$clog2(ENTRY_NUM)-1:0]  alloc0_id_o,
  input  logic                          alloc1_vld_i,
  output logic                          alloc1_rdy_o,
  output logic [$clog2(ENTRY_NUM)-1:0]  alloc1_id_o,
  input  logic                          free0_vld_i,
  input  logic [$clog2(ENTRY_NUM)-1:0]  free0_id_i,
  input  logic                          free1_vld_i,
  input  logic [$clog2(ENTRY_NUM)-1:0]  free1_id_i,
  input  logic                          flush_i,
  output logic [ENTRY_NUM-1:0]          busy_mask_o,
  output logic [$clog2(ENTRY_NUM+1)-1:0] busy_cnt_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic                          err_o
);

  localparam int ENTRY_ID_W = $clog2(ENTRY_NUM);
  localparam int CNT_W      = $clog2(ENTRY_NUM + 1);
  localparam logic [CNT_W-1:0] C_FULL_CNT = CNT_W'(ENTRY_NUM);

  logic [ENTRY_NUM-1:0]  r_busy;
  logic [CNT_W-1:0]      r_cnt;

  logic                  w_first_vld;
  logic [ENTRY_ID_W-1:0] w_first_id;
  logic                  w_second_vld;
  logic [ENTRY_ID_W-1:0] w_second_id;

  logic                  w_fire0;
  logic                  w_fire1;
  logic [ENTRY_NUM-1:0]  w_f0_hit;
  logic [ENTRY_NUM-1:0]  w_f1_hit;
  logic [ENTRY_NUM-1:0]  w_set_mask;
  logic [ENTRY_NUM-1:0]  w_clr_mask;
  logic [ENTRY_NUM-1:0]  w_busy_d;
  logic [CNT_W-1:0]      w_cnt_d;

  function automatic logic [CNT_W-1:0] popcnt(input logic [ENTRY_NUM-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  // The selector sees only the registered busy state. An entry freed this
  // cycle can therefore be granted no earlier than the next cycle.
  select_two_from_n_valid #(
    .N    (ENTRY_NUM),
    .ID_W (ENTRY_ID_W)
  ) u_sel (
    .sel_i                  (~r_busy),
    .first_id_needed_vld_i  (alloc0_vld_i),
    .second_id_needed_vld_i (alloc1_vld_i),
    .first_id_vld_o         (w_first_vld),
    .first_id_o             (w_first_id),
    .second_id_vld_o        (w_second_vld),
    .second_id_o            (w_second_id)
  );

  assign alloc0_rdy_o = w_first_vld  & ~flush_i;
  assign alloc1_rdy_o = w_second_vld & ~flush_i;
  assign alloc0_id_o  = w_first_id;
  assign alloc1_id_o  = w_second_id;

  assign w_fire0 = alloc0_vld_i & alloc0_rdy_o;
  assign w_fire1 = alloc1_vld_i & alloc1_rdy_o;

  // Per-entry id decode. An id outside the pool matches no entry, so a
  // release of that id has no effect. If both release ports name the same
  // busy entry, the OR of the two hits clears that entry once.
  generate
    for (genvar i = 0; i < ENTRY_NUM; i++) begin : g_entry
      assign w_f0_hit[i]   = free0_vld_i & (free0_id_i == ENTRY_ID_W'(i));
      assign w_f1_hit[i]   = free1_vld_i & (free1_id_i == ENTRY_ID_W'(i));
      assign w_clr_mask[i] = (w_f0_hit[i] | w_f1_hit[i]) & r_busy[i];
      assign w_set_mask[i] = (w_fire0 & (w_first_id  == ENTRY_ID_W'(i))) |
                             (w_fire1 & (w_second_id == ENTRY_ID_W'(i)));
    end
  endgenerate

  assign w_busy_d = (r_busy & ~w_clr_mask) | w_set_mask;
  assign w_cnt_d  = r_cnt + CNT_W'(w_fire0) + CNT_W'(w_fire1) - popcnt(w_clr_mask);

  // Busy bitmap and occupancy counter. A flush overrides all same-cycle activity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
      r_cnt  <= '0;
    end else if (flush_i) begin
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      r_busy <= w_busy_d;
      r_cnt  <= w_cnt_d;
    end
  end

  assign busy_mask_o = r_busy;
  assign busy_cnt_o  = r_cnt;
  assign full_o      = (r_cnt == C_FULL_CNT);
  assign empty_o     = (r_cnt == '0);

`ifdef L1D_ALLOC_TRACKER_CHK_EN
  logic r_err;
  logic w_bad_free0;
  logic w_bad_free1;
  logic w_cnt_mismatch;
  logic w_err_evt;

  // A release is bad if its id matches no busy entry. This covers both an
  // already-free entry and an out-of-range id.
  assign w_bad_free0    = free0_vld_i & ~(|(w_f0_hit & r_busy));
  assign w_bad_free1    = free1_vld_i & ~(|(w_f1_hit & r_busy));
  assign w_cnt_mismatch = (popcnt(r_busy) != r_cnt);
  assign w_err_evt      = w_bad_free0 | w_bad_free1 | w_cnt_mismatch;

  // Sticky error flag. It is cleared only by reset or by a flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (flush_i) begin
      r_err <= 1'b0;
    end else begin
      r_err <= r_err | w_err_evt;
    end
  end

  assign err_o = r_err;

  a_no_proto_err : assert property (@(posedge clk) disable iff (rst) !w_err_evt)
    else $error("tracker protocol error: bad free or count/bitmap disagreement");
`else
  assign err_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/l1d_dual_entry_alloc_tracker.md
Name: l1d_dual_entry_alloc_tracker

Overview:
- Tracks busy/free state of an N-entry pool (e.g. L1D MSHR / line-fill-buffer entries) and grants up to two entry allocations and two entry releases per cycle.
- Drives the free mask into an internal select_two_from_n_valid instance.
- Consumes the two selected ids to issue allocations over valid/ready ports, then updates the busy bitmap and occupancy counter.

Parameters:
- ENTRY_NUM, 8, number of tracked entries (>=2).
- ENTRY_ID_W, $clog2(ENTRY_NUM), entry id width (derived localparam).
- CNT_W, $clog2(ENTRY_NUM+1), occupancy counter width (derived localparam).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- alloc0_vld_i  input  1  allocation request, port 0.
- alloc0_rdy_o  output  1  port 0 can be granted this cycle.
- alloc0_id_o  output  ENTRY_ID_W  id granted to port 0.
- alloc1_vld_i  input  1  allocation request, port 1.
- alloc1_rdy_o  output  1  port 1 can be granted this cycle.
- alloc1_id_o  output  ENTRY_ID_W  id granted to port 1.
- free0_vld_i  input  1  release request, port 0.
- free0_id_i  input  ENTRY_ID_W  entry released by port 0.
- free1_vld_i  input  1  release request, port 1.
- free1_id_i  input  ENTRY_ID_W  entry released by port 1.
- flush_i  input  1  release all entries.
- busy_mask_o  output  ENTRY_NUM  registered busy bitmap.
- busy_cnt_o  output  CNT_W  registered number of busy entries.
- full_o  output  1  busy_cnt_o == ENTRY_NUM.
- empty_o  output  1  busy_cnt_o == 0.
- err_o  output  1  sticky protocol-error flag (see Optional Feature).

Behaviour:
- State: busy_q[ENTRY_NUM-1:0] and cnt_q[CNT_W-1:0].
  - Async reset clears busy_q and cnt_q.
  - Reset values: empty_o=1, full_o=0, err_o=0, alloc*_rdy_o follow the reset state (all entries free).
- Selector hookup (combinational):
  - sel_i = ~busy_q.
  - first_id_needed_vld_i = alloc0_vld_i; second_id_needed_vld_i = alloc1_vld_i.
- Port 0:
  - alloc0_rdy_o = first_id_vld_o; alloc0_id_o = first_id_o (lowest free index).
- Port 1:
  - alloc1_rdy_o = second_id_vld_o; alloc1_id_o = second_id_o (highest free index).
  - With exactly one free entry and both ports requesting, port 0 wins and alloc1_rdy_o=0.
  - If alloc0_vld_i=0, port 1 may take that single entry.
- Fire and free conditions:
  - Fire: allocN_fire = allocN_vld_i & allocN_rdy_o.
  - The rdy signals depend combinationally on the vld inputs, so requesters must not make vld depend on rdy.
  - freeN_eff = freeN_vld_i & busy_q[freeN_id_i].
  - If both free ports name the same id, it is cleared once and counted once.
- Update, next edge, zero-cycle latency to grant:
  - busy_d = (busy_q & ~free_clr_mask) | alloc_set_mask.
  - cnt_d = cnt_q + fires − distinct effective frees.
  - Counter never wraps: the rules above guarantee 0..ENTRY_NUM.
- Allocation never uses an entry freed in the same cycle. The selector sees busy_q, so freed entries become grantable one cycle later.
  - An allocated id can therefore never collide with a same-cycle free.
- flush_i:
  - Next state busy_q=0, cnt_q=0.
  - Overrides same-cycle fires and frees; alloc*_rdy_o are forced to 0 while flush_i=1.
- Full: both rdy outputs are 0 and requests are held off.
- Out-of-range ids (>= ENTRY_NUM, non-power-of-2 sizes) on a free port are ignored.
- Reset asserted mid-operation clears all state immediately; in-flight requests are dropped.
- busy_mask_o, busy_cnt_o, full_o and empty_o are pure register outputs (no input-to-output path).

Optional Feature:
- Macro L1D_ALLOC_TRACKER_CHK_EN.
- Defined: err_o is a sticky register that sets on the edge after any of:
  - freeN_vld_i on a non-busy entry;
  - freeN_vld_i with an out-of-range id;
  - popcount(busy_q) != cnt_q.
  - err_o clears only on rst or flush_i.
  - Simulation-only assertions also fire on these conditions.
- Not defined: err_o tied to 0; no popcount checker logic, no assertions.

Test Plan:
- Reset then both allocs valid with ENTRY_NUM=8 -> ids 0 and 7 granted; next cycle busy_mask_o=8'h81, busy_cnt_o=2.
- busy_mask=8'h7F (only entry 7 free), both allocs valid -> alloc0_rdy_o=1, id 7; alloc1_rdy_o=0; next cycle full_o=1.
- Same mask, only alloc1 valid -> alloc1_rdy_o=1, id 7; next cycle busy_cnt_o=8.
- Full pool, free0 id 3 with both allocs valid in the same cycle -> no grant that cycle; next cycle alloc0 granted id 3, busy_cnt_o 7→8.
- free0 and free1 both id 5 on busy entry 5 -> busy_cnt_o drops by exactly 1. With CHK_EN, a second free of id 5 later -> err_o=1 next cycle.
- flush_i asserted with alloc0 valid on busy_mask=8'h0F -> alloc0_rdy_o=0; next cycle busy_mask_o=0, empty_o=1, err_o=0.
